enigma_stream_adapter: RTL and testbench
========================================

Name: enigma_stream_adapter

Overview:
- Host-side front/back end sitting directly upstream and downstream of the enigma cipher core.
- Accepts an ASCII byte stream from the host (valid/ready) and maps letters to index 0..25. Issues one character at a time to the core (single-cycle valid pulse plus din) and waits for the core's done pulse.
- Converts the returned index back to ASCII and buffers results in a small output FIFO (valid/ready).
- Non-letters bypass the core in order. A watchdog guards against a core that never answers.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2).
- TIMEOUT, 255, max cycles spent in WAIT before abort (≥1).
- CASE_PRESERVE, 1, 1: lowercase input yields lowercase output; 0: output always uppercase.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host ASCII byte.
- in_ready  out  1  adapter accepts in_data this cycle.
- core_valid  out  1  one-cycle request pulse to core.
- core_din  out  8  letter index 0..25 to core.
- core_done  in  1  core result pulse.
- core_dout  in  8  core result index.
- out_valid  out  1  FIFO head valid.
- out_data  out  8  FIFO head ASCII byte.
- out_ready  in  1  host consumes head.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky: watchdog fired.
- err_range  out  1  sticky: core_dout > 25 seen.
- clr_err  in  1  clears both sticky flags.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high; one clk with reset=1 suffices): state=IDLE, FIFO empty, fifo_count=0, in_ready=0 during reset, core_valid=0, core_din=0, out_valid=0, out_data=0, busy=0, err flags=0, watchdog=0. Reset mid-transaction discards the pending character and all FIFO contents. A late core_done after reset is ignored because IDLE ignores core_done.
- in_ready = (state==IDLE) && (fifo_count < FIFO_DEPTH) && !reset. There is exactly one character outstanding at a time, so a FIFO slot is always reserved before acceptance.
- States:
  - IDLE: on in_valid && in_ready, latch byte.
    - 'A'..'Z': idx=byte-8'h41, lower=0 -> ISSUE.
    - 'a'..'z': idx=byte-8'h61, lower=1 -> ISSUE.
    - else: result=byte (bypass) -> PUSH.
  - ISSUE: core_valid=1, core_din=idx for exactly this cycle; watchdog cleared -> WAIT.
  - WAIT: core_valid=0.
    - core_done=1: if core_dout<=25, result = core_dout + (lower&&CASE_PRESERVE ? 8'h61 : 8'h41); else result=8'h3F ('?') and set err_range. -> PUSH.
    - Otherwise watchdog increments. When watchdog reaches TIMEOUT (core_done=0 that cycle): result=8'h3F, set err_timeout -> PUSH.
    - core_done on the same cycle the watchdog reaches TIMEOUT: the result wins and no timeout is flagged.
  - PUSH: write result to FIFO tail -> IDLE.
- core_done outside WAIT is ignored.
- Latency:
  - Letter: accept at cycle N, core_valid at N+1, core_done at M≥N+2, PUSH at M+1, out_valid visible at M+2 if the FIFO was empty.
  - Bypass: accept at N, PUSH at N+1, out_valid at N+2.
  - Back-to-back acceptance is possible at PUSH+1.
- FIFO: out_valid = !empty; out_data = head (registered storage, stable while out_valid && !out_ready). A pop occurs on out_valid && out_ready. Push and pop in the same cycle are both allowed, including at full-minus-one; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH. Overflow cannot occur by construction.
- Sticky errors: set as above; clr_err clears them on the next edge. Set and clr in the same cycle: set wins.
- Ordering: output byte order equals input byte order, including bypassed bytes.

Test Plan:
- Reset, then in 'H'(0x48) with core model returning idx+3 after 5 cycles -> core_valid pulse with core_din=7 exactly one cycle; out_data=0x4B ('K') at core_done+2; in_ready=0 while busy.
- "a b" with CASE_PRESERVE=1, core returning idx+1 -> outputs 0x62, 0x20, 0x63 in order; the space never produces core_valid and appears 2 cycles after acceptance.
- Core never asserts core_done, TIMEOUT=8 -> after 8 WAIT cycles, out_data=0x3F, err_timeout=1 and stays set until clr_err pulse, then 0.
- Core returns 30 -> out_data=0x3F, err_range=1; next letter processed normally.
- out_ready held 0, stream 5 letters with FIFO_DEPTH=4 -> fifo_count reaches 4, in_ready stays 0 with the 5th byte pending; release out_ready -> simultaneous pop/push keeps order, all 5 delivered.
- Assert reset during WAIT with 2 bytes queued -> next cycle fifo_count=0, out_valid=0, state IDLE; a core_done arriving afterwards produces no output.

Source files
------------

// File: rtl/enigma_stream_adapter.sv
// Host ASCII stream adapter for the enigma core: maps letters to 0..25, issues them one at a time,
// maps results back to ASCII and queues them (with bypassed non-letters) in an output FIFO.
module enigma_stream_adapter #(
   parameter int FIFO_DEPTH    = 4,
   parameter int TIMEOUT       = 255,
   parameter int CASE_PRESERVE = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [7:0]                  in_data,
   output logic                        in_ready,
   output logic                        core_valid,
   output logic [7:0]                  core_din,
   input  logic                        core_done,
   input  logic [7:0]                  core_dout,
   output logic                        out_valid,
   output logic [7:0]                  out_data,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        err_timeout,
   output logic                        err_range,
   input  logic                        clr_err,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // Watchdog only needs to hold 0..TIMEOUT-1; the expiring cycle is detected, not stored.
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_t;

   state_t          state, next_state;
   logic [7:0]      idx;
   logic            lower;
   logic [7:0]      result;
   logic [WW-1:0]   watchdog;
   logic [7:0]      base;
   logic            is_upper, is_lower, accept, wd_expire, push, pop;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;

   always_comb begin
      is_upper   = (in_data >= 8'h41) && (in_data <= 8'h5A);
      is_lower   = (in_data >= 8'h61) && (in_data <= 8'h7A);
      in_ready   = (state == IDLE) && (fifo_count < CW'(FIFO_DEPTH)) && !reset;
      accept     = in_valid && in_ready;
      wd_expire  = (watchdog == WW'(TIMEOUT - 1));
      base       = (lower && (CASE_PRESERVE != 0)) ? 8'h61 : 8'h41;
      busy       = (state != IDLE);
      core_valid = (state == ISSUE);
      core_din   = (state == ISSUE) ? idx : '0;
      push       = (state == PUSH);
      out_valid  = (fifo_count != '0);
      out_data   = out_valid ? mem[rd_ptr] : '0;
      pop        = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (is_upper || is_lower) ? ISSUE : PUSH;
         ISSUE:   next_state = WAIT;
         WAIT:    if (core_done || wd_expire) next_state = PUSH;
         PUSH:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Error sets are assigned after the clear so a coincident set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx         <= '0;
         lower       <= 1'b0;
         result      <= '0;
         watchdog    <= '0;
         err_timeout <= 1'b0;
         err_range   <= 1'b0;
      end else begin
         if (clr_err) begin
            err_timeout <= 1'b0;
            err_range   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_upper) begin
                     idx   <= in_data - 8'h41;
                     lower <= 1'b0;
                  end else if (is_lower) begin
                     idx   <= in_data - 8'h61;
                     lower <= 1'b1;
                  end else begin
                     result <= in_data;
                  end
               end
            end
            ISSUE: watchdog <= '0;
            WAIT: begin
               if (core_done) begin
                  if (core_dout <= 8'd25) begin
                     result <= core_dout + base;
                  end else begin
                     result    <= 8'h3F;
                     err_range <= 1'b1;
                  end
               end else if (wd_expire) begin
                  result      <= 8'h3F;
                  err_timeout <= 1'b1;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= result;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_enigma_stream_adapter.sv
// Scoreboard bench for enigma_stream_adapter with a behavioural core model
// (configurable latency, index offset, forced result or silence).
module tb_enigma_stream_adapter;

   localparam int FIFO_DEPTH    = 4;
   localparam int TIMEOUT       = 8;
   localparam int CASE_PRESERVE = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       core_valid;
   logic [7:0] core_din;
   logic       core_done = 1'b0;
   logic [7:0] core_dout = 8'h00;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       err_timeout;
   logic       err_range;
   logic       clr_err = 1'b0;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q [$];

   int   core_delay = 1;
   int   core_add   = 0;
   int   core_force = -1;
   bit   core_mute  = 1'b0;
   int   cv_count   = 0;
   int   pend_cnt   = 0;
   logic [7:0] pend_val = 8'h00;

   enigma_stream_adapter #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .TIMEOUT      (TIMEOUT),
      .CASE_PRESERVE(CASE_PRESERVE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .core_valid (core_valid),
      .core_din   (core_din),
      .core_done  (core_done),
      .core_dout  (core_dout),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .err_timeout(err_timeout),
      .err_range  (err_range),
      .clr_err    (clr_err),
      .fifo_count (fifo_count)
   );

   initial forever #5 clk = ~clk;

   // Core model: sees a request in the ISSUE cycle, answers core_delay cycles later.
   initial forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            core_done = 1'b1;
            core_dout = pend_val;
         end
      end
      if (core_valid) begin
         cv_count++;
         if (!core_mute) begin
            pend_cnt = core_delay;
            pend_val = (core_force >= 0) ? 8'(core_force) : 8'(int'(core_din) + core_add);
         end
      end
   end

   // Output monitor: compares every popped byte against the scoreboard.
   initial forever begin
      logic [7:0] e;
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got %02h, required no output", out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL out_data: got %02h, required %02h", out_data, e);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic [7:0] e, input bit track);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_accept %02h: in_ready %b, required 1", b, in_ready);
      end else if (track) begin
         exp_q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle: busy %b, required 0", busy);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_fifo: out_valid %b out_data %02h count %0d, required 0 00 0",
                  out_valid, out_data, fifo_count);
      end
      n_checks++;
      if (busy !== 1'b0 || core_valid !== 1'b0 || core_din !== 8'h00 ||
          err_timeout !== 1'b0 || err_range !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy %b core_valid %b core_din %02h errs %b%b, required all 0",
                  busy, core_valid, core_din, err_timeout, err_range);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_letter;
      int c0;
      c0 = cv_count;
      core_delay = 5; core_add = 3; core_force = -1; core_mute = 1'b0;
      out_ready = 1'b1;
      send(8'h48, 8'h4B, 1'b1);
      n_checks++;
      if (core_valid !== 1'b1 || core_din !== 8'd7) begin
         n_fail++; $display("FAIL letter_issue: core_valid %b din %0d, required 1 7", core_valid, core_din);
      end
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL letter_busy: in_ready %b busy %b, required 0 1", in_ready, busy);
      end
      @(negedge clk);
      n_checks++;
      if (core_valid !== 1'b0) begin
         n_fail++; $display("FAIL letter_pulse_width: core_valid %b, required 0", core_valid);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL letter_early: out_valid %b in_ready %b, required 0 0", out_valid, in_ready);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h4B) begin
         n_fail++; $display("FAIL letter_result: out_valid %b data %02h, required 1 4b", out_valid, out_data);
      end
      n_checks++;
      if (cv_count - c0 !== 1) begin
         n_fail++; $display("FAIL letter_pulse_count: got %0d, required 1", cv_count - c0);
      end
   endtask

   task automatic test_bypass;
      int c0;
      core_delay = 2; core_add = 1;
      out_ready = 1'b1;
      send(8'h61, 8'h62, 1'b1);
      wait_idle();
      c0 = cv_count;
      send(8'h20, 8'h20, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bypass_lat1: out_valid %b, required 0", out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h20 || cv_count !== c0) begin
         n_fail++;
         $display("FAIL bypass_lat2: out_valid %b data %02h core pulses %0d, required 1 20 0",
                  out_valid, out_data, cv_count - c0);
      end
      send(8'h62, 8'h63, 1'b1);
      wait_idle();
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL bypass_drain: %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_timeout;
      core_mute = 1'b1;
      out_ready = 1'b1;
      send(8'h51, 8'h3F, 1'b1);
      repeat (8) @(negedge clk);
      n_checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL timeout_early: err %b busy %b, required 0 1", err_timeout, busy);
      end
      @(negedge clk);
      n_checks++;
      if (err_timeout !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_flag: err %b out_valid %b, required 1 0", err_timeout, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3F) begin
         n_fail++; $display("FAIL timeout_result: out_valid %b data %02h, required 1 3f", out_valid, out_data);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (err_timeout !== 1'b1) begin
         n_fail++; $display("FAIL timeout_sticky: got %b, required 1", err_timeout);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      n_checks++;
      if (err_timeout !== 1'b0 || err_range !== 1'b0) begin
         n_fail++; $display("FAIL timeout_clear: errs %b%b, required 00", err_timeout, err_range);
      end
      core_mute = 1'b0;
   endtask

   task automatic test_range;
      core_delay = 1; core_force = 30;
      out_ready = 1'b1;
      send(8'h43, 8'h3F, 1'b1);
      wait_idle();
      n_checks++;
      if (err_range !== 1'b1 || err_timeout !== 1'b0) begin
         n_fail++; $display("FAIL range_flag: err_range %b err_timeout %b, required 1 0", err_range, err_timeout);
      end
      core_force = -1; core_add = 3;
      send(8'h64, 8'h67, 1'b1);
      wait_idle();
      @(negedge clk);
      n_checks++;
      if (err_range !== 1'b1) begin
         n_fail++; $display("FAIL range_sticky: got %b, required 1", err_range);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      n_checks++;
      if (err_range !== 1'b0) begin
         n_fail++; $display("FAIL range_clear: got %b, required 0", err_range);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int n;
      out_ready = 1'b0;
      core_delay = 1; core_add = 0; core_force = -1;
      send(8'h41, 8'h41, 1'b1);
      send(8'h42, 8'h42, 1'b1);
      send(8'h43, 8'h43, 1'b1);
      send(8'h44, 8'h44, 1'b1);
      wait_idle();
      n_checks++;
      if (fifo_count !== 3'd4 || in_ready !== 1'b0 || out_data !== 8'h41) begin
         n_fail++;
         $display("FAIL full_state: count %0d in_ready %b head %02h, required 4 0 41",
                  fifo_count, in_ready, out_data);
      end
      in_valid = 1'b1; in_data = 8'h45;
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL full_hold: in_ready %b busy %b, required 0 0", in_ready, busy);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || fifo_count !== 3'd3) begin
         n_fail++; $display("FAIL full_release: in_ready %b count %0d, required 1 3", in_ready, fifo_count);
      end
      exp_q.push_back(8'h45);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (fifo_count !== 3'd3) begin
         n_fail++; $display("FAIL pushpop_before: count %0d, required 3", fifo_count);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fifo_count !== 3'd3 || out_data !== 8'h43) begin
         n_fail++; $display("FAIL pushpop_same_cycle: count %0d head %02h, required 3 43", fifo_count, out_data);
      end
      n = 0;
      while (fifo_count != 3'd0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
         n_fail++; $display("FAIL drain_all: %0d pending count %0d, required 0 0", exp_q.size(), fifo_count);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      out_ready = 1'b0;
      core_delay = 6; core_add = 0; core_force = -1;
      send(8'h20, 8'h00, 1'b0);
      send(8'h21, 8'h00, 1'b0);
      wait_idle();
      n_checks++;
      if (fifo_count !== 3'd2) begin
         n_fail++; $display("FAIL midreset_queued: count %0d, required 2", fifo_count);
      end
      send(8'h5A, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL midreset_in_ready: got %b, required 0", in_ready);
      end
      reset = 1'b0;
      exp_q.delete();
      n_checks++;
      if (fifo_count !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_clear: count %0d out_valid %b busy %b data %02h, required 0 0 0 00",
                  fifo_count, out_valid, busy, out_data);
      end
      out_ready = 1'b1;
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || fifo_count !== 3'd0 || core_valid !== 1'b0) ok = 1'b0;
      end
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL midreset_late_done: out_valid %b count %0d, required 0 0", out_valid, fifo_count);
      end
   endtask

   initial begin
      test_reset();
      test_letter();
      test_bypass();
      test_timeout();
      test_range();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
